// File: rtl/button_enable_pulse.sv
// button_enable_pulse: debounce a raw pushbutton into one-cycle enable pulses with optional auto-repeat
module button_enable_pulse #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 0,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic en_pulse,
  output logic btn_level,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES > 0 ? REPEAT_CYCLES - 1 : 0);
  state_t state, state_d;
  logic s1, btn_s, pulse_d;
  logic [CNT_W-1:0] cnt, cnt_d, rpt, rpt_d, cnt_inc, rpt_inc;
  assign cnt_inc = cnt + {{(CNT_W-1){1'b0}}, ~&cnt};
  assign rpt_inc = rpt + {{(CNT_W-1){1'b0}}, ~&rpt};
  // next-state, counter and pulse decisions from the synchronised button only
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rpt_d   = rpt;
    pulse_d = 1'b0;
    case (state)
      IDLE: if (btn_s) begin
        state_d = PRESS_WAIT;
        cnt_d   = '0;
      end
      PRESS_WAIT: if (!btn_s) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (cnt == DB_LAST) begin
        state_d = PRESSED;
        pulse_d = 1'b1;
        cnt_d   = '0;
        rpt_d   = '0;
      end else cnt_d = cnt_inc;
      PRESSED: if (!btn_s) begin
        state_d = RELEASE_WAIT;
        cnt_d   = '0;
        rpt_d   = '0;
      end else if (REPEAT_CYCLES > 0) begin
        pulse_d = rpt == RP_LAST;
        rpt_d   = rpt == RP_LAST ? '0 : rpt_inc;
      end
      RELEASE_WAIT: if (btn_s) begin
        state_d = PRESSED;
        cnt_d   = '0;
        rpt_d   = '0;
      end else if (cnt == DB_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else cnt_d = cnt_inc;
      default: state_d = IDLE;
    endcase
  end
  // synchroniser, state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= 1'b0;
      btn_s     <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      rpt       <= '0;
      en_pulse  <= 1'b0;
      btn_level <= 1'b0;
      busy      <= 1'b0;
    end else begin
      s1        <= btn_in;
      btn_s     <= s1;
      state     <= state_d;
      cnt       <= cnt_d;
      rpt       <= rpt_d;
      en_pulse  <= pulse_d;
      btn_level <= state_d == PRESSED || state_d == RELEASE_WAIT;
      busy      <= state_d == PRESS_WAIT || state_d == RELEASE_WAIT;
    end
  end
endmodule

// File: tb/tb_button_enable_pulse.sv
// tb_button_enable_pulse: scoreboard bench comparing two debouncer configurations against a run-length model
module tb_button_enable_pulse;
  localparam int D = 4;
  logic clk = 1'b0, rst_n = 1'b0, btn_in = 1'b0;
  logic [1:0] en, lvl, bsy;
  int checks = 0, passed = 0;
  int pc [2] = '{0, 0};
  bit m_s1, m_s;
  bit m_lvl [2];
  int mis [2], hold [2];
  logic [5:0] q [$];

  button_enable_pulse #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .en_pulse(en[0]), .btn_level(lvl[0]), .busy(bsy[0]));
  button_enable_pulse #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(8), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .en_pulse(en[1]), .btn_level(lvl[1]), .busy(bsy[1]));

  always #5 clk = ~clk;

  function automatic int rp(input int i);
    return i == 1 ? 8 : 0;
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
  endtask

  // reference: the level flips once the synchronised button disagrees with it for D+1 samples;
  // while held, a repeat fires every rp() samples since the level was (re)confirmed
  always @(posedge clk or negedge rst_n) begin
    bit b, p;
    logic [5:0] e;
    if (!rst_n) begin
      m_s1 = 0; m_s = 0;
      for (int i = 0; i < 2; i++) begin m_lvl[i] = 0; mis[i] = 0; hold[i] = 0; end
      q.delete();
    end else begin
      b = m_s; m_s = m_s1; m_s1 = btn_in;
      e = '0;
      for (int i = 0; i < 2; i++) begin
        p = 0;
        if (b != m_lvl[i]) begin
          mis[i]++;
          if (mis[i] == D + 1) begin m_lvl[i] = b; mis[i] = 0; hold[i] = 0; p = b; end
        end else if (m_lvl[i]) begin
          if (mis[i] > 0) begin mis[i] = 0; hold[i] = 0; end
          else begin
            hold[i]++;
            if (rp(i) > 0 && hold[i] == rp(i)) begin p = 1; hold[i] = 0; end
          end
        end else mis[i] = 0;
        e[i*3 +: 3] = {p, m_lvl[i], mis[i] > 0};
      end
      q.push_back(e);
    end
  end

  // monitor: pop one expectation per clock and compare both DUTs
  always @(negedge clk) begin
    logic [5:0] e, a;
    a = {en[1], lvl[1], bsy[1], en[0], lvl[0], bsy[0]};
    e = '0;
    if (rst_n && q.size() > 0) e = q.pop_front();
    check("dut0 {en,lvl,busy}", {3'b0, a[2:0]}, {3'b0, e[2:0]});
    check("dut1 {en,lvl,busy}", {3'b0, a[5:3]}, {3'b0, e[5:3]});
    pc[0] += int'(en[0]);
    pc[1] += int'(en[1]);
  end

  task automatic drive(input logic v, input int n);
    btn_in = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulses(input string name, input int i, input int base, input int exp);
    check(name, 6'(pc[i] - base), 6'(exp));
  endtask

  initial begin
    int c0, c1;
    rst_n = 0; btn_in = 1;
    repeat (10) @(posedge clk);
    #2;
    pulses("reset no pulse", 0, 0, 0);
    btn_in = 0; rst_n = 1;
    drive(0, 5);
    c0 = pc[0]; c1 = pc[1];
    drive(1, 20); drive(0, 15);
    pulses("clean press pulses", 0, c0, 1);
    c0 = pc[0];
    for (int k = 0; k < 4; k++) begin drive(1, 2); drive(0, 2); end
    drive(0, 10);
    pulses("bounce pulses", 0, c0, 0);
    c0 = pc[0];
    drive(1, 12); drive(0, 2); drive(1, 10); drive(0, 15);
    pulses("release glitch pulses", 0, c0, 1);
    c0 = pc[0]; c1 = pc[1];
    drive(1, 50); drive(0, 15);
    pulses("repeat dut1 pulses", 1, c1, 6);
    pulses("repeat off dut0 pulses", 0, c0, 1);
    c0 = pc[0];
    for (int k = 0; k < 4; k++) begin drive(1, 10); drive(0, 12); end
    pulses("four presses", 0, c0, 4);
    c0 = pc[0]; c1 = pc[1];
    drive(1, 5);
    rst_n = 0; btn_in = 0;
    #3;
    drive(0, 3);
    rst_n = 1;
    drive(0, 15);
    pulses("reset mid press dut0", 0, c0, 0);
    pulses("reset mid press dut1", 1, c1, 0);
    for (int k = 0; k < 60; k++) drive(1'($urandom_range(0, 1)), $urandom_range(1, 12));
    drive(0, 20);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
